tx_burst_bit_counter: RTL and testbench

- Parametrised transmit bit/beat counter for the I2C master datapath.
- Tracks the bit index within the current beat and the beats remaining in a burst.
- Validates the burst/size request and flags illegal requests.
- Reports last-bit, last-beat and completion to the transmit FSM and shift register.

---
 rtl/tx_burst_bit_counter.sv | 132 +++++++++++++
 tb/tb_tx_burst_bit_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_bit_counter.sv
// tx_burst_bit_counter: transmit bit/beat counter for the I2C master datapath.
// Tracks the bit index within a beat (MSB first) and the beats left in a burst,
// validates the burst/size request and reports last-bit/last-beat/done/err.
// Optional macro TXCNT_PAUSE_EN adds a pause input and a paused output.
// Parameter sets must satisfy MAX_SIZE*8 <= 2**BIT_W.
module tx_burst_bit_counter #(
    parameter int BURST_W  = 7,
    parameter int SIZE_W   = 4,
    parameter int MAX_SIZE = 4,
    parameter int BIT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               dec,
    input  logic [BURST_W-1:0] burst,
    input  logic [SIZE_W-1:0]  size,
`ifdef TXCNT_PAUSE_EN
    input  logic               pause,
`endif
    output logic [BIT_W-1:0]   bit_cnt,
    output logic [BURST_W-1:0] beat_cnt,
    output logic               busy,
    output logic               last_bit,
    output logic               last_beat,
    output logic               done,
    output logic               err
`ifdef TXCNT_PAUSE_EN
    ,
    output logic               paused
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic burst_ok, size_ok, step;

    // Index of the first (MSB) bit of a beat: size*8-1, kept at BIT_W bits.
    function automatic logic [BIT_W-1:0] top_bit(input logic [SIZE_W-1:0] s);
        return BIT_W'((32'(s) << 3) - 32'd1);
    endfunction

    // Request legality: burst a nonzero power of two within range, size 1/2/4 and <= MAX_SIZE.
    always_comb begin
        burst_ok = (burst != '0) && ((burst & (burst - BURST_W'(1))) == '0)
                   && (32'(burst) <= (32'd1 << (BURST_W - 1)));
        size_ok  = ((size == SIZE_W'(1)) || (size == SIZE_W'(2)) || (size == SIZE_W'(4)))
                   && (32'(size) <= MAX_SIZE);
    end

    // A bit is consumed only when dec is high and (optionally) not paused.
`ifdef TXCNT_PAUSE_EN
    assign step = dec && !pause;
`else
    assign step = dec;
`endif

    // Next-state: load wins over everything; otherwise RUN consumes one bit per step.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        beat_cnt_d = beat_cnt_q;
        size_d     = size_q;
        done_d     = 1'b0;
        err_d      = err_q;
        if (load) begin
            if (burst_ok && size_ok) begin
                state_d    = RUN;
                beat_cnt_d = burst;
                bit_cnt_d  = top_bit(size);
                size_d     = size;
                err_d      = 1'b0;
            end else begin
                state_d    = ERR;
                beat_cnt_d = '0;
                bit_cnt_d  = '0;
                size_d     = '0;
                err_d      = 1'b1;
            end
        end else if (state_q == RUN && step) begin
            if (bit_cnt_q != '0) begin
                bit_cnt_d = bit_cnt_q - BIT_W'(1);
            end else if (beat_cnt_q > BURST_W'(1)) begin
                beat_cnt_d = beat_cnt_q - BURST_W'(1);
                bit_cnt_d  = top_bit(size_q);
            end else begin
                beat_cnt_d = '0;
                bit_cnt_d  = '0;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
        end
    end

    // State and counter registers; async reset clears everything, no done on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            beat_cnt_q <= '0;
            size_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            size_q     <= size_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bit_cnt   = bit_cnt_q;
    assign beat_cnt  = beat_cnt_q;
    assign busy      = (state_q == RUN);
    assign last_bit  = busy && (bit_cnt_q == '0);
    assign last_beat = busy && (beat_cnt_q == BURST_W'(1));
    assign done      = done_q;
    assign err       = err_q;
`ifdef TXCNT_PAUSE_EN
    assign paused    = busy && pause;
`endif

endmodule

// File: tb/tb_tx_burst_bit_counter.sv
// Directed bench for tx_burst_bit_counter (default parameters).
module tb_tx_burst_bit_counter;

    logic       clk = 1'b0;
    logic       rst_n, load, dec;
    logic [6:0] burst;
    logic [3:0] size;
    logic [4:0] bit_cnt;
    logic [6:0] beat_cnt;
    logic       busy, last_bit, last_beat, done, err;
`ifdef TXCNT_PAUSE_EN
    logic       pause, paused;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tx_burst_bit_counter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .dec      (dec),
        .burst    (burst),
        .size     (size),
`ifdef TXCNT_PAUSE_EN
        .pause    (pause),
        .paused   (paused),
`endif
        .bit_cnt  (bit_cnt),
        .beat_cnt (beat_cnt),
        .busy     (busy),
        .last_bit (last_bit),
        .last_beat(last_beat),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input int b, input int bt, input bit bz,
                           input bit dn, input bit er);
        check({tag, ".bit"}, 32'(bit_cnt), b);
        check({tag, ".beat"}, 32'(beat_cnt), bt);
        check({tag, ".busy"}, 32'(busy), 32'(bz));
        check({tag, ".done"}, 32'(done), 32'(dn));
        check({tag, ".err"}, 32'(err), 32'(er));
    endtask

    task automatic do_load(input int b, input int s);
        burst = 7'(b);
        size  = 4'(s);
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b1; dec = 1'b1; burst = 7'd2; size = 4'd1;
`ifdef TXCNT_PAUSE_EN
        pause = 1'b0;
`endif
        // Reset held with load/dec active: nothing moves.
        tick(3);
        chk_all("rst", 0, 0, 0, 0, 0);
        check("rst.last_bit", 32'(last_bit), 0);
        check("rst.last_beat", 32'(last_beat), 0);
        load = 1'b0; dec = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 0, 0, 0, 0, 0);

        // burst=2, size=1: 16 pulses, bits 7..0 twice.
        do_load(2, 1);
        chk_all("b2s1.load", 7, 2, 1, 0, 0);
        check("b2s1.last_beat0", 32'(last_beat), 0);
        dec = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("b2s1.bit", 32'(bit_cnt), 7 - (k % 8));
            check("b2s1.beat", 32'(beat_cnt), (k < 8) ? 2 : 1);
            check("b2s1.last_bit", 32'(last_bit), ((k % 8) == 7) ? 1 : 0);
            check("b2s1.last_beat", 32'(last_beat), (k < 8) ? 0 : 1);
            check("b2s1.done", 32'(done), 0);
        end
        tick();
        chk_all("b2s1.end", 0, 0, 0, 1, 0);
        check("b2s1.end_last_bit", 32'(last_bit), 0);
        tick();
        chk_all("b2s1.idle_dec", 0, 0, 0, 0, 0);
        dec = 1'b0;

        // burst=1, size=4 with a 3-cycle gap in dec.
        do_load(1, 4);
        chk_all("b1s4.load", 31, 1, 1, 0, 0);
        check("b1s4.last_beat", 32'(last_beat), 1);
        dec = 1'b1;
        tick(16);
        check("b1s4.bit16", 32'(bit_cnt), 15);
        dec = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b1s4.gap_bit", 32'(bit_cnt), 15);
        end
        dec = 1'b1;
        tick(15);
        chk_all("b1s4.p31", 0, 1, 1, 0, 0);
        check("b1s4.p31_last_bit", 32'(last_bit), 1);
        tick();
        chk_all("b1s4.p32", 0, 0, 0, 1, 0);
        dec = 1'b0;
        tick();
        check("b1s4.done_clr", 32'(done), 0);

        // Illegal requests.
        do_load(3, 1);
        chk_all("ill.b3", 0, 0, 0, 0, 1);
        dec = 1'b1;
        tick();
        chk_all("ill.dec", 0, 0, 0, 0, 1);
        dec = 1'b0;
        do_load(2, 3);
        chk_all("ill.s3", 0, 0, 0, 0, 1);
        do_load(0, 1);
        chk_all("ill.b0", 0, 0, 0, 0, 1);
        do_load(1, 8);
        chk_all("ill.s8", 0, 0, 0, 0, 1);
        do_load(4, 2);
        chk_all("ill.clear", 15, 4, 1, 0, 0);

        // Abort mid-run with load+dec; size latched at load.
        do_load(2, 1);
        dec = 1'b1;
        tick(3);
        check("abort.pre_bit", 32'(bit_cnt), 4);
        burst = 7'd4; size = 4'd2; load = 1'b1;
        tick();
        load = 1'b0;
        chk_all("abort.load", 15, 4, 1, 0, 0);
        size = 4'd1; burst = 7'd1;
        tick(16);
        chk_all("abort.latched", 15, 3, 1, 0, 0);
        dec = 1'b0;

        // Async reset mid-burst at bit=3, beat=2.
        do_load(2, 1);
        dec = 1'b1;
        tick(4);
        chk_all("mid.pre", 3, 2, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all("mid.async", 0, 0, 0, 0, 0);
        tick();
        chk_all("mid.held", 0, 0, 0, 0, 0);
        dec = 1'b0;
        rst_n = 1'b1;
        tick();

`ifdef TXCNT_PAUSE_EN
        // Pause freezes counters; load overrides pause.
        do_load(2, 1);
        dec = 1'b1;
        tick(2);
        check("pause.pre", 32'(bit_cnt), 5);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pause.bit", 32'(bit_cnt), 5);
            check("pause.beat", 32'(beat_cnt), 2);
            check("pause.paused", 32'(paused), 1);
        end
        pause = 1'b0;
        tick();
        check("pause.resume", 32'(bit_cnt), 4);
        check("pause.paused0", 32'(paused), 0);
        pause = 1'b1;
        do_load(1, 1);
        chk_all("pause.load", 7, 1, 1, 0, 0);
        pause = 1'b0; dec = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
